um_s4: RTL and testbench

Stage-4 user module (`um`) of the packet-processing pipeline, between the port/CPU input stream and the network output stream. It inspects a type nibble in the third beat of every 134-bit packet. Control packets (type 4'hf) go to the DMA/host path; all other packets go out on the network output. It also provides a free-running timer and localbus-readable packet statistics. The match-engine interface is tied off.

---
 rtl/um_s4.sv | 253 +++++++++++++++++++++++++
 tb/tb_um_s4.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/um_s4.sv
// um_s4: stage-4 user module. Packets whose third beat carries type 4'hf go to the DMA path, others to the network.
// Optional feature: define UM_LOCALBUS_STATS_EN to build the packet counters readable over the localbus.
module um_s4 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [63:0]  um_timestamp,
  input  logic [133:0] pktin_data,
  input  logic         pktin_data_wr,
  input  logic         pktin_data_valid,
  input  logic         pktin_data_valid_wr,
  output logic         pktin_ready,
  output logic [133:0] pktout_data,
  output logic         pktout_data_wr,
  output logic         pktout_data_valid,
  output logic         pktout_data_valid_wr,
  input  logic         pktout_ready,
  output logic [133:0] um2dma_data,
  output logic         um2dma_data_wr,
  input  logic         dma2um_ready,
  input  logic [133:0] dma2um_data,
  input  logic         dma2um_data_wr,
  output logic         um2dma_ready,
  output logic         um2me_key_wr,
  output logic         um2me_key_valid,
  output logic [511:0] um2match_key,
  output logic         um2match_gme_alful,
  input  logic         um2me_ready,
  input  logic         me2um_id_wr,
  input  logic [15:0]  match2um_id,
  input  logic         ctrl_valid,
  input  logic         ctrl2um_cs_n,
  input  logic         ctrl_cmd,
  input  logic [31:0]  ctrl_addr,
  input  logic [31:0]  ctrl_datain,
  output logic [31:0]  ctrl_dataout,
  output logic         um2ctrl_ack_n,
  output logic [63:0]  um_timer
);

  localparam logic [3:0] CTRL_TYPE  = 4'hf;
  localparam int         PIPE_DEPTH = 3;
  localparam int         LAST       = PIPE_DEPTH - 1;

  typedef enum logic {PKT_IDLE, PKT_OPEN} pkt_state_t;

  pkt_state_t state, state_next;
  logic [1:0] beat_cnt, beat_cnt_next;
  logic       pkt_ctrl, pkt_ctrl_next;

  logic [133:0] st_data     [PIPE_DEPTH];
  logic         st_wr       [PIPE_DEPTH];
  logic         st_valid    [PIPE_DEPTH];
  logic         st_valid_wr [PIPE_DEPTH];
  logic         st_ctrl     [PIPE_DEPTH];
  logic         st_first    [PIPE_DEPTH];
  logic         st_err      [PIPE_DEPTH];

  logic [1:0] in_pos;
  logic       in_start;
  logic       in_end;
  logic       in_first;
  logic [1:0] beat_idx;
  logic       ctrl_hit;
  logic       in_ctrl;
  logic       in_abort;

  logic        lb_txn;
  logic        lb_read;
  logic        lb_write;
  logic [31:0] rd_value;

  logic unused_inputs;

  assign um2dma_ready       = 1'b0;
  assign um2me_key_wr       = 1'b0;
  assign um2me_key_valid    = 1'b0;
  assign um2match_key       = '0;
  assign um2match_gme_alful = 1'b0;

  assign unused_inputs = ^{um_timestamp, pktout_ready, dma2um_ready, dma2um_data, dma2um_data_wr,
                           um2me_ready, me2um_id_wr, match2um_id, ctrl_datain};

  // Classify the incoming beat. Beat 2 can only promote its packet when beat 0 sits in stage 1
  // (and therefore beat 1 in stage 0); otherwise beat 0 has already left and the packet stays DATA.
  always_comb begin
    in_pos   = pktin_data[133:132];
    in_start = (in_pos == 2'b01) || (in_pos == 2'b00);
    in_end   = (in_pos == 2'b10) || (in_pos == 2'b00);
    in_first = in_start || (state == PKT_IDLE);
    beat_idx = in_first ? 2'd0 : beat_cnt;
    ctrl_hit = pktin_data_wr && (beat_idx == 2'd2) && (pktin_data[11:8] == CTRL_TYPE)
               && st_wr[1] && st_first[1];
    in_ctrl  = pktin_data_wr && (ctrl_hit || (!in_first && pkt_ctrl));
    in_abort = pktin_data_wr && in_start && (state == PKT_OPEN);
  end

  always_comb begin
    state_next    = state;
    beat_cnt_next = beat_cnt;
    pkt_ctrl_next = pkt_ctrl;
    case (state)
      PKT_IDLE, PKT_OPEN: begin
        if (pktin_data_wr) begin
          state_next    = in_end ? PKT_IDLE : PKT_OPEN;
          beat_cnt_next = (beat_idx == 2'd3) ? 2'd3 : beat_idx + 2'd1;
          pkt_ctrl_next = in_ctrl;
        end
      end
      default: state_next = PKT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PKT_IDLE;
      beat_cnt <= 2'd0;
      pkt_ctrl <= 1'b0;
    end else begin
      state    <= state_next;
      beat_cnt <= beat_cnt_next;
      pkt_ctrl <= pkt_ctrl_next;
    end
  end

  // Fixed-depth shift pipeline; a CTRL hit also promotes the two older beats of the same packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        st_data[i]     <= '0;
        st_wr[i]       <= 1'b0;
        st_valid[i]    <= 1'b0;
        st_valid_wr[i] <= 1'b0;
        st_ctrl[i]     <= 1'b0;
        st_first[i]    <= 1'b0;
        st_err[i]      <= 1'b0;
      end
    end else begin
      st_data[0]     <= pktin_data;
      st_wr[0]       <= pktin_data_wr;
      st_valid[0]    <= pktin_data_valid;
      st_valid_wr[0] <= pktin_data_valid_wr;
      st_ctrl[0]     <= in_ctrl;
      st_first[0]    <= pktin_data_wr && in_first;
      st_err[0]      <= in_abort;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        st_data[i]     <= st_data[i-1];
        st_wr[i]       <= st_wr[i-1];
        st_valid[i]    <= st_valid[i-1];
        st_valid_wr[i] <= st_valid_wr[i-1];
        st_ctrl[i]     <= (st_ctrl[i-1] || ctrl_hit) && st_wr[i-1];
        st_first[i]    <= st_first[i-1];
        st_err[i]      <= st_err[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pktout_data          <= '0;
      pktout_data_wr       <= 1'b0;
      pktout_data_valid    <= 1'b0;
      pktout_data_valid_wr <= 1'b0;
      um2dma_data          <= '0;
      um2dma_data_wr       <= 1'b0;
    end else begin
      pktout_data_wr       <= 1'b0;
      pktout_data_valid_wr <= 1'b0;
      um2dma_data_wr       <= 1'b0;
      if (st_ctrl[LAST]) begin
        if (st_wr[LAST]) begin
          um2dma_data    <= st_data[LAST];
          um2dma_data_wr <= 1'b1;
        end
      end else begin
        if (st_wr[LAST]) begin
          pktout_data    <= st_data[LAST];
          pktout_data_wr <= 1'b1;
        end
        if (st_valid_wr[LAST]) begin
          pktout_data_valid    <= st_valid[LAST];
          pktout_data_valid_wr <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pktin_ready <= 1'b0;
      um_timer    <= '0;
    end else begin
      pktin_ready <= 1'b1;
      um_timer    <= um_timer + 64'd1;
    end
  end

  assign lb_txn   = ctrl_valid && !ctrl2um_cs_n;
  assign lb_read  = lb_txn && ctrl_cmd;
  assign lb_write = lb_txn && !ctrl_cmd;

`ifdef UM_LOCALBUS_STATS_EN
  logic [31:0] data_pkt_cnt;
  logic [31:0] ctrl_pkt_cnt;
  logic [31:0] err_cnt;
  logic        tail_out;

  assign tail_out = st_wr[LAST] && ((st_data[LAST][133:132] == 2'b10) || (st_data[LAST][133:132] == 2'b00));

  // A clearing write takes priority over any increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_pkt_cnt <= '0;
      ctrl_pkt_cnt <= '0;
      err_cnt      <= '0;
    end else if (lb_write) begin
      data_pkt_cnt <= '0;
      ctrl_pkt_cnt <= '0;
      err_cnt      <= '0;
    end else begin
      if (tail_out && !st_ctrl[LAST]) data_pkt_cnt <= data_pkt_cnt + 32'd1;
      if (tail_out && st_ctrl[LAST])  ctrl_pkt_cnt <= ctrl_pkt_cnt + 32'd1;
      if (st_wr[LAST] && st_err[LAST]) err_cnt <= err_cnt + 32'd1;
    end
  end

  always_comb begin
    rd_value = '0;
    case (ctrl_addr)
      32'd0:   rd_value = data_pkt_cnt;
      32'd1:   rd_value = ctrl_pkt_cnt;
      32'd2:   rd_value = err_cnt;
      32'd3:   rd_value = um_timer[31:0];
      default: rd_value = '0;
    endcase
  end
`else
  logic unused_stats;

  assign rd_value     = '0;
  assign unused_stats = ^{ctrl_addr, lb_write, st_err[LAST]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      um2ctrl_ack_n <= 1'b1;
      ctrl_dataout  <= '0;
    end else begin
      um2ctrl_ack_n <= !lb_txn;
      if (lb_read) ctrl_dataout <= rd_value;
    end
  end

endmodule

// File: tb/tb_um_s4.sv
// tb_um_s4: table-driven bench for um_s4 (routing, latency, localbus counters, reset behaviour).
`timescale 1ns/1ps
module tb_um_s4;

  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] NET  = 2'd1;
  localparam logic [1:0] DMA  = 2'd2;

`ifdef UM_LOCALBUS_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [63:0]  um_timestamp = '0;
  logic [133:0] pktin_data = '0;
  logic         pktin_data_wr = 1'b0;
  logic         pktin_data_valid = 1'b0;
  logic         pktin_data_valid_wr = 1'b0;
  logic         pktin_ready;
  logic [133:0] pktout_data;
  logic         pktout_data_wr;
  logic         pktout_data_valid;
  logic         pktout_data_valid_wr;
  logic         pktout_ready = 1'b1;
  logic [133:0] um2dma_data;
  logic         um2dma_data_wr;
  logic         dma2um_ready = 1'b1;
  logic [133:0] dma2um_data = '0;
  logic         dma2um_data_wr = 1'b0;
  logic         um2dma_ready;
  logic         um2me_key_wr;
  logic         um2me_key_valid;
  logic [511:0] um2match_key;
  logic         um2match_gme_alful;
  logic         um2me_ready = 1'b0;
  logic         me2um_id_wr = 1'b0;
  logic [15:0]  match2um_id = '0;
  logic         ctrl_valid = 1'b0;
  logic         ctrl2um_cs_n = 1'b1;
  logic         ctrl_cmd = 1'b0;
  logic [31:0]  ctrl_addr = '0;
  logic [31:0]  ctrl_datain = '0;
  logic [31:0]  ctrl_dataout;
  logic         um2ctrl_ack_n;
  logic [63:0]  um_timer;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] tb_cycles;

  typedef struct {
    logic [133:0] data;
    logic         wr;
    logic         vwr;
    logic [1:0]   route;
    logic         exp_vwr;
  } vec_t;

  vec_t vecs[$];

  um_s4 dut (
    .clk(clk), .rst_n(rst_n), .um_timestamp(um_timestamp),
    .pktin_data(pktin_data), .pktin_data_wr(pktin_data_wr),
    .pktin_data_valid(pktin_data_valid), .pktin_data_valid_wr(pktin_data_valid_wr),
    .pktin_ready(pktin_ready),
    .pktout_data(pktout_data), .pktout_data_wr(pktout_data_wr),
    .pktout_data_valid(pktout_data_valid), .pktout_data_valid_wr(pktout_data_valid_wr),
    .pktout_ready(pktout_ready),
    .um2dma_data(um2dma_data), .um2dma_data_wr(um2dma_data_wr),
    .dma2um_ready(dma2um_ready), .dma2um_data(dma2um_data), .dma2um_data_wr(dma2um_data_wr),
    .um2dma_ready(um2dma_ready),
    .um2me_key_wr(um2me_key_wr), .um2me_key_valid(um2me_key_valid),
    .um2match_key(um2match_key), .um2match_gme_alful(um2match_gme_alful),
    .um2me_ready(um2me_ready), .me2um_id_wr(me2um_id_wr), .match2um_id(match2um_id),
    .ctrl_valid(ctrl_valid), .ctrl2um_cs_n(ctrl2um_cs_n), .ctrl_cmd(ctrl_cmd),
    .ctrl_addr(ctrl_addr), .ctrl_datain(ctrl_datain), .ctrl_dataout(ctrl_dataout),
    .um2ctrl_ack_n(um2ctrl_ack_n), .um_timer(um_timer)
  );

  always #5 clk = ~clk;

  // Reference cycle count: clears with reset, advances on every clock otherwise.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cycles <= '0;
    else        tb_cycles <= tb_cycles + 64'd1;
  end

  function automatic logic [133:0] mkBeat(input logic [1:0] pos, input logic [15:0] tag);
    return {pos, 4'h0, tag, 96'h0, tag};
  endfunction

  function automatic logic [133:0] mkType(input logic [1:0] pos, input logic [3:0] t);
    return {pos, 4'h0, 48'h1, 48'h2, 20'h0, t, 8'h0};
  endfunction

  task automatic addVec(input logic [133:0] d, input logic wr, input logic vwr,
                        input logic [1:0] route, input logic exp_vwr);
    vec_t v;
    v.data = d; v.wr = wr; v.vwr = vwr; v.route = route; v.exp_vwr = exp_vwr;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [133:0] actual, input logic [133:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [133:0] d, input logic wr, input logic vwr);
    pktin_data          = d;
    pktin_data_wr       = wr;
    pktin_data_valid    = vwr;
    pktin_data_valid_wr = vwr;
  endtask

  task automatic checkVec(input int j);
    checkOutput($sformatf("v%0d pktout_wr", j), pktout_data_wr, vecs[j].route == NET);
    checkOutput($sformatf("v%0d dma_wr", j), um2dma_data_wr, vecs[j].route == DMA);
    if (vecs[j].route == NET) checkOutput($sformatf("v%0d pktout_data", j), pktout_data, vecs[j].data);
    if (vecs[j].route == DMA) checkOutput($sformatf("v%0d dma_data", j), um2dma_data, vecs[j].data);
    checkOutput($sformatf("v%0d valid_wr", j), pktout_data_valid_wr, vecs[j].exp_vwr);
    if (vecs[j].exp_vwr) checkOutput($sformatf("v%0d valid", j), pktout_data_valid, 1'b1);
  endtask

  // Each vector's result is sampled three clocks after it was written.
  task automatic runVectors(input int first, input int last);
    for (int i = first; i <= last + 3; i++) begin
      @(negedge clk);
      if (i <= last) applyStimulus(vecs[i].data, vecs[i].wr, vecs[i].vwr);
      else           applyStimulus('0, 1'b0, 1'b0);
      @(posedge clk); #1;
      if (i - 3 >= first) checkVec(i - 3);
    end
  endtask

  task automatic lbAccess(input logic cmd, input logic [31:0] addr, input logic [31:0] exp,
                          input bit use_timer, input string name);
    logic [31:0] want;
    @(negedge clk);
    want = use_timer ? (STATS_EN ? tb_cycles[31:0] : 32'd0) : exp;
    ctrl_valid = 1'b1; ctrl2um_cs_n = 1'b0; ctrl_cmd = cmd; ctrl_addr = addr; ctrl_datain = 32'h55;
    @(posedge clk); #1;
    checkOutput({name, " ack"}, um2ctrl_ack_n, 1'b0);
    if (cmd) checkOutput({name, " data"}, ctrl_dataout, want);
    @(negedge clk);
    ctrl_valid = 1'b0; ctrl2um_cs_n = 1'b1; ctrl_cmd = 1'b0; ctrl_addr = '0;
    @(posedge clk); #1;
    checkOutput({name, " ack release"}, um2ctrl_ack_n, 1'b1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " pktout_wr"}, pktout_data_wr, 1'b0);
    checkOutput({tag, " pktout_valid"}, pktout_data_valid, 1'b0);
    checkOutput({tag, " pktout_valid_wr"}, pktout_data_valid_wr, 1'b0);
    checkOutput({tag, " pktout_data"}, pktout_data, '0);
    checkOutput({tag, " dma_wr"}, um2dma_data_wr, 1'b0);
    checkOutput({tag, " dma_data"}, um2dma_data, '0);
    checkOutput({tag, " ack_n"}, um2ctrl_ack_n, 1'b1);
    checkOutput({tag, " dataout"}, ctrl_dataout, '0);
    checkOutput({tag, " timer"}, um_timer, '0);
    checkOutput({tag, " pktin_ready"}, pktin_ready, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seg1_end, seg2_end, seg3_end;

    // A: 6-beat control packet, B: same packet with type 0.
    addVec(mkBeat(2'b01, 16'h0A00), 1, 0, DMA, 0);
    addVec(mkBeat(2'b11, 16'h0A01), 1, 0, DMA, 0);
    addVec(mkType(2'b11, 4'hf),     1, 0, DMA, 0);
    addVec(mkBeat(2'b11, 16'h0A03), 1, 0, DMA, 0);
    addVec(mkBeat(2'b11, 16'h0A04), 1, 0, DMA, 0);
    addVec(mkBeat(2'b10, 16'h0A05), 1, 1, DMA, 0);
    addVec(mkBeat(2'b01, 16'h0B00), 1, 0, NET, 0);
    addVec(mkBeat(2'b11, 16'h0B01), 1, 0, NET, 0);
    addVec(mkType(2'b11, 4'h0),     1, 0, NET, 0);
    addVec(mkBeat(2'b11, 16'h0B03), 1, 0, NET, 0);
    addVec(mkBeat(2'b11, 16'h0B04), 1, 0, NET, 0);
    addVec(mkBeat(2'b10, 16'h0B05), 1, 1, NET, 1);
    seg1_end = vecs.size() - 1;
    // C: 2-beat data, 2-cycle gap, D: 6-beat control.
    addVec(mkBeat(2'b01, 16'h0C00), 1, 0, NET, 0);
    addVec(mkBeat(2'b10, 16'h0C01), 1, 1, NET, 1);
    addVec('0, 0, 0, NONE, 0);
    addVec('0, 0, 0, NONE, 0);
    addVec(mkBeat(2'b01, 16'h0D00), 1, 0, DMA, 0);
    addVec(mkBeat(2'b11, 16'h0D01), 1, 0, DMA, 0);
    addVec(mkType(2'b11, 4'hf),     1, 0, DMA, 0);
    addVec(mkBeat(2'b11, 16'h0D03), 1, 0, DMA, 0);
    addVec(mkBeat(2'b11, 16'h0D04), 1, 0, DMA, 0);
    addVec(mkBeat(2'b10, 16'h0D05), 1, 1, DMA, 0);
    // E: beat 0 drains before the type beat arrives, so it stays DATA.
    addVec(mkBeat(2'b01, 16'h0E00), 1, 0, NET, 0);
    addVec('0, 0, 0, NONE, 0);
    addVec('0, 0, 0, NONE, 0);
    addVec(mkBeat(2'b11, 16'h0E01), 1, 0, NET, 0);
    addVec(mkType(2'b10, 4'hf),     1, 1, NET, 1);
    // F is cut short by G's head; G completes normally.
    addVec(mkBeat(2'b01, 16'h0100), 1, 0, NET, 0);
    addVec(mkBeat(2'b11, 16'h0101), 1, 0, NET, 0);
    addVec(mkBeat(2'b01, 16'h0200), 1, 0, NET, 0);
    addVec(mkBeat(2'b10, 16'h0201), 1, 1, NET, 1);
    seg2_end = vecs.size() - 1;
    // I: short data packet after a mid-packet reset.
    addVec(mkBeat(2'b01, 16'h0400), 1, 0, NET, 0);
    addVec(mkBeat(2'b10, 16'h0401), 1, 1, NET, 1);
    seg3_end = vecs.size() - 1;

    #2 rst_n = 1'b0;
    #4 checkResetState("reset");
    checkOutput("tieoff dma_ready", um2dma_ready, 1'b0);
    checkOutput("tieoff key", {um2me_key_wr, um2me_key_valid, um2match_gme_alful, (|um2match_key)}, '0);
    #1 rst_n = 1'b1;
    #1 checkOutput("pktin_ready before clock", pktin_ready, 1'b0);
    @(posedge clk); #1;
    checkOutput("pktin_ready after clock", pktin_ready, 1'b1);

    runVectors(0, seg1_end);
    lbAccess(1'b1, 32'd0, STATS_EN ? 32'd1 : 32'd0, 0, "rd data_cnt");
    lbAccess(1'b1, 32'd1, STATS_EN ? 32'd1 : 32'd0, 0, "rd ctrl_cnt");
    lbAccess(1'b1, 32'd2, 32'd0, 0, "rd err_cnt");
    lbAccess(1'b0, 32'd0, 32'd0, 0, "wr clear");
    lbAccess(1'b1, 32'd0, 32'd0, 0, "rd data_cnt cleared");
    lbAccess(1'b1, 32'd1, 32'd0, 0, "rd ctrl_cnt cleared");
    lbAccess(1'b1, 32'd2, 32'd0, 0, "rd err_cnt cleared");

    runVectors(seg1_end + 1, seg2_end);
    lbAccess(1'b1, 32'd0, STATS_EN ? 32'd3 : 32'd0, 0, "rd data_cnt seg2");
    lbAccess(1'b1, 32'd1, STATS_EN ? 32'd1 : 32'd0, 0, "rd ctrl_cnt seg2");
    lbAccess(1'b1, 32'd2, STATS_EN ? 32'd1 : 32'd0, 0, "rd err_cnt seg2");
    lbAccess(1'b1, 32'd3, 32'd0, 1, "rd timer");
    lbAccess(1'b1, 32'd7, 32'd0, 0, "rd unmapped");
    checkOutput("um_timer", um_timer, tb_cycles);

    // Reset lands while beat 3 of packet H is being written: nothing of H may come out.
    @(negedge clk) applyStimulus(mkBeat(2'b01, 16'h0300), 1'b1, 1'b0);
    @(negedge clk) applyStimulus(mkBeat(2'b11, 16'h0301), 1'b1, 1'b0);
    @(negedge clk) applyStimulus(mkBeat(2'b11, 16'h0302), 1'b1, 1'b0);
    @(negedge clk) applyStimulus(mkBeat(2'b11, 16'h0303), 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 checkResetState("mid reset");
    @(negedge clk) applyStimulus('0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("post reset %0d pktout_wr", k), pktout_data_wr, 1'b0);
      checkOutput($sformatf("post reset %0d dma_wr", k), um2dma_data_wr, 1'b0);
    end

    runVectors(seg2_end + 1, seg3_end);
    lbAccess(1'b1, 32'd0, STATS_EN ? 32'd1 : 32'd0, 0, "rd data_cnt seg3");
    lbAccess(1'b1, 32'd1, 32'd0, 0, "rd ctrl_cnt seg3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
